// File: rtl/cpu_types_pkg.sv
// Shared types for the coherent data cache: MSI line state, controller state,
// address split and line layout, plus a block-address helper.
package cpu_types_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 25;
  localparam int IDX_W  = 4;
  localparam int SETS   = 16;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [3:0] {
    IDLE, SNOOP, SNOOP_WB0, SNOOP_WB1, WB0, WB1,
    ALLOC0, ALLOC1, FLUSH_WB0, FLUSH_WB1, FLUSHED
  } dstate_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } daddr_t;

  typedef struct packed {
    msi_t              msi;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] w1;
  } dline_t;

  function automatic logic [DATA_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/coherent_dcache.sv
// Direct-mapped, 16-set, 2-word-block write-back data cache with MSI snooping,
// write-back/allocate bus sequencing and a halt-triggered flush walk.
module coherent_dcache
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [DATA_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  input  logic              halt,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              flushed,
  output logic              dREN,
  output logic              dWEN,
  output logic              ccwrite,
  output logic [DATA_W-1:0] daddr,
  output logic [DATA_W-1:0] dstore,
  input  logic [DATA_W-1:0] dload,
  input  logic              dwait,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [DATA_W-1:0] ccsnoopaddr,
  output logic              cctrans
);

  dline_t           lines [SETS];
  dstate_t          state;
  logic [IDX_W-1:0] flush_cnt;
  logic [TAG_W-1:0] snp_tag;
  logic [IDX_W-1:0] snp_idx;
  logic             snp_inv;
  logic             done;
  logic             alloc_busy;

  daddr_t req, snp_in;
  dline_t rline, sline, fline;
  logic   tag_hit, victim_dirty, snp_match, snp_mhit, preempt, flush_last;
  logic   unused_bits;

  assign req          = dmemaddr;
  assign snp_in       = ccsnoopaddr;
  assign rline        = lines[req.idx];
  assign sline        = lines[snp_idx];
  assign fline        = lines[flush_cnt];
  assign tag_hit      = (rline.tag == req.tag);
  assign victim_dirty = (rline.msi == MSI_M) && !tag_hit;
  assign snp_match    = (sline.msi != MSI_I) && (sline.tag == snp_tag);
  assign snp_mhit     = snp_match && (sline.msi == MSI_M);
  assign flush_last   = (flush_cnt == 4'hF);
  assign flushed      = done;
  assign dmemload     = req.blkoff ? rline.w1 : rline.w0;
  assign unused_bits  = ^{req.bytoff, snp_in.blkoff, snp_in.bytoff};

  // A refill may be displaced by a snoop only before its first bus cycle.
  assign preempt = (state == ALLOC0) && ccwait && !alloc_busy;

  always_comb begin
    dhit = 1'b0;
    if (state == IDLE && !ccwait && !halt && tag_hit) begin
      if (dmemWEN)      dhit = (rline.msi == MSI_M);
      else if (dmemREN) dhit = (rline.msi != MSI_I);
    end
  end

  always_comb begin
    dREN    = 1'b0;
    dWEN    = 1'b0;
    ccwrite = 1'b0;
    cctrans = 1'b0;
    daddr   = '0;
    dstore  = '0;
    unique case (state)
      SNOOP: begin
        cctrans = 1'b1;
        dWEN    = snp_mhit;
        daddr   = blk_addr(snp_tag, snp_idx, 1'b0);
        dstore  = sline.w0;
      end
      SNOOP_WB0: begin
        dWEN = 1'b1; daddr = blk_addr(snp_tag, snp_idx, 1'b0); dstore = sline.w0;
      end
      SNOOP_WB1: begin
        dWEN = 1'b1; daddr = blk_addr(snp_tag, snp_idx, 1'b1); dstore = sline.w1;
      end
      WB0: begin
        dWEN = 1'b1; daddr = blk_addr(rline.tag, req.idx, 1'b0); dstore = rline.w0;
      end
      WB1: begin
        dWEN = 1'b1; daddr = blk_addr(rline.tag, req.idx, 1'b1); dstore = rline.w1;
      end
      ALLOC0: begin
        dREN    = !preempt;
        ccwrite = dmemWEN && !preempt;
        daddr   = preempt ? '0 : blk_addr(req.tag, req.idx, 1'b0);
      end
      ALLOC1: begin
        dREN = 1'b1; ccwrite = dmemWEN; daddr = blk_addr(req.tag, req.idx, 1'b1);
      end
      FLUSH_WB0: begin
        dWEN = 1'b1; daddr = blk_addr(fline.tag, flush_cnt, 1'b0); dstore = fline.w0;
      end
      FLUSH_WB1: begin
        dWEN = 1'b1; daddr = blk_addr(fline.tag, flush_cnt, 1'b1); dstore = fline.w1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      snp_tag    <= '0;
      snp_idx    <= '0;
      snp_inv    <= 1'b0;
      done       <= 1'b0;
      alloc_busy <= 1'b0;
      for (int i = 0; i < SETS; i++) lines[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ccwait) begin
            snp_tag <= snp_in.tag; snp_idx <= snp_in.idx; snp_inv <= ccinv;
            state   <= SNOOP;
          end else if (halt) begin
            if (fline.msi == MSI_M) state <= FLUSH_WB0;
            else begin
              lines[flush_cnt].msi <= MSI_I;
              if (flush_last) begin state <= FLUSHED; done <= 1'b1; end
              else flush_cnt <= flush_cnt + 4'd1;
            end
          end else if (dhit) begin
            if (dmemWEN) begin
              if (req.blkoff) lines[req.idx].w1 <= dmemstore;
              else            lines[req.idx].w0 <= dmemstore;
            end
          end else if (dmemREN || dmemWEN) begin
            state <= victim_dirty ? WB0 : ALLOC0;
          end
        end
        SNOOP: begin
          if (snp_mhit) state <= SNOOP_WB0;
          else begin
            if (snp_match && snp_inv) lines[snp_idx].msi <= MSI_I;
            state <= done ? FLUSHED : IDLE;
          end
        end
        SNOOP_WB0: if (!dwait) state <= SNOOP_WB1;
        SNOOP_WB1: begin
          if (!dwait) begin
            lines[snp_idx].msi <= snp_inv ? MSI_I : MSI_S;
            state <= done ? FLUSHED : IDLE;
          end
        end
        WB0: if (!dwait) state <= WB1;
        WB1: begin
          // Victim is now clean in memory; drop it so a snoop sees no stale copy.
          if (!dwait) begin lines[req.idx].msi <= MSI_I; state <= ALLOC0; end
        end
        ALLOC0: begin
          if (preempt) begin
            snp_tag <= snp_in.tag; snp_idx <= snp_in.idx; snp_inv <= ccinv;
            state   <= SNOOP;
          end else begin
            alloc_busy <= 1'b1;
            if (!dwait) begin
              lines[req.idx].msi <= MSI_I;
              lines[req.idx].w0  <= dload;
              alloc_busy <= 1'b0;
              state      <= ALLOC1;
            end
          end
        end
        ALLOC1: begin
          if (!dwait) begin
            lines[req.idx].w1  <= dload;
            lines[req.idx].tag <= req.tag;
            lines[req.idx].msi <= dmemWEN ? MSI_M : MSI_S;
            state <= IDLE;
          end
        end
        FLUSH_WB0: if (!dwait) state <= FLUSH_WB1;
        FLUSH_WB1: begin
          if (!dwait) begin
            lines[flush_cnt].msi <= MSI_I;
            if (flush_last) begin state <= FLUSHED; done <= 1'b1; end
            else begin flush_cnt <= flush_cnt + 4'd1; state <= IDLE; end
          end
        end
        FLUSHED: begin
          if (ccwait) begin
            snp_tag <= snp_in.tag; snp_idx <= snp_in.idx; snp_inv <= ccinv;
            state   <= SNOOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_dcache.sv
// Bench for coherent_dcache: memory/bus responder plus a line-level cache and
// coherent-memory reference model, directed scenarios and a random phase.
module tb_coherent_dcache;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, halt, dhit, flushed;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dREN, dWEN, ccwrite, dwait, ccwait, ccinv, cctrans;
  logic [31:0] daddr, dstore, dload, ccsnoopaddr;

  coherent_dcache dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .ccwrite(ccwrite), .daddr(daddr), .dstore(dstore), .dload(dload),
    .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .cctrans(cctrans)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic        cc;
    logic [31:0] d;
  } bus_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  bus_t        blog [$];
  logic        rand_lat = 1'b0;
  logic        mv [16];
  logic        md [16];
  logic [24:0] mt [16];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction
  function automatic logic model_hit(input logic [31:0] a, input logic we);
    return mv[a[6:3]] && (mt[a[6:3]] == a[31:7]) && (!we || md[a[6:3]]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end
  endtask

  // Memory slave: optional random wait per word; snoop-ack cycles carry no data.
  initial begin
    int wl;
    wl = 0; dwait = 1'b1; dload = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin dwait = 1'b1; wl = 0; end
      else begin
        chk("ren_wen_exclusive", {31'd0, dREN & dWEN}, 32'd0);
        if ((dREN || dWEN) && !cctrans) begin
          if (wl > 0) begin dwait = 1'b1; wl--; end
          else begin
            dwait = 1'b0;
            dload = mem_rd(daddr);
            if (dWEN) mem[daddr] = dstore;
            blog.push_back('{daddr, dWEN, ccwrite, dWEN ? dstore : mem_rd(daddr)});
            wl = rand_lat ? int'($urandom_range(0, 2)) : 0;
          end
        end else dwait = 1'b1;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, dREN, dWEN, ccwrite, cctrans, dhit, flushed}, 32'd0);
    chk({tag, "_daddr"}, daddr, 32'd0);
    chk({tag, "_dstore"}, dstore, 32'd0);
    chk({tag, "_dmemload"}, dmemload, 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    ccwait = 1'b0; ccinv = 1'b0; dmemaddr = '0; dmemstore = '0; ccsnoopaddr = '0;
    #1;
    chk_reset_outputs("reset");
    tick(); tick();
    nRST = 1'b1;
    model_clear();
  endtask

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] d);
    int   n;
    logic ph;
    ph = model_hit(a, we);
    dmemaddr = a; dmemREN = !we; dmemWEN = we; dmemstore = d;
    #1;
    chk("first_cycle_hit", {31'd0, dhit}, {31'd0, ph});
    n = 0;
    while (!dhit && n < 80) begin tick(); n++; end
    chk("hit_within_budget", {31'd0, dhit}, 32'd1);
    if (!we) chk("read_data", dmemload, ref_rd(a));
    tick();
    dmemREN = 1'b0; dmemWEN = 1'b0;
    if (we) refm[a] = d;
    md[a[6:3]] = we ? 1'b1 : (ph & md[a[6:3]]);
    mv[a[6:3]] = 1'b1;
    mt[a[6:3]] = a[31:7];
  endtask

  task automatic snoop(input logic [31:0] a, input logic inv);
    int          n;
    logic        mh, sh;
    logic [31:0] blk;
    blk = {a[31:3], 3'b000};
    sh  = mv[a[6:3]] && (mt[a[6:3]] == a[31:7]);
    mh  = sh && md[a[6:3]];
    blog.delete();
    ccwait = 1'b1; ccinv = inv; ccsnoopaddr = a;
    #1;
    n = 0;
    while (!cctrans && n < 40) begin tick(); n++; end
    chk("snoop_ack", {31'd0, cctrans}, 32'd1);
    chk("snoop_dwen", {31'd0, dWEN}, {31'd0, mh});
    chk("snoop_daddr", daddr, blk);
    tick();
    ccwait = 1'b0;
    chk("cctrans_single_cycle", {31'd0, cctrans}, 32'd0);
    n = 0;
    while ((dWEN || dREN) && n < 40) begin tick(); n++; end
    chk("snoop_wb_words", blog.size(), mh ? 32'd2 : 32'd0);
    if (mh) begin
      chk("snoop_wb_word0", mem_rd(blk), ref_rd(blk));
      chk("snoop_wb_word1", mem_rd(blk + 4), ref_rd(blk + 4));
    end
    if (sh) begin
      if (inv) mv[a[6:3]] = 1'b0;
      md[a[6:3]] = 1'b0;
    end
  endtask

  task automatic chk_log(input int i, input logic [31:0] a, input logic w, input logic cc);
    bus_t e;
    e = '{32'hFFFF_FFFF, 1'bx, 1'bx, 32'h0};
    if (i < blog.size()) e = blog[i];
    chk("log_addr", e.a, a);
    chk("log_kind", {30'd0, e.w, e.cc}, {30'd0, w, cc});
  endtask

  task automatic do_flush();
    int n;
    halt = 1'b1;
    n = 0;
    while (!flushed && n < 400) begin tick(); n++; end
    chk("flushed_set", {31'd0, flushed}, 32'd1);
    model_clear();
  endtask

  initial begin
    int   n;
    logic [31:0] a;
    model_clear();
    mem[32'h40] = 32'h0000_AAAA; refm[32'h40] = 32'h0000_AAAA;
    mem[32'h44] = 32'h0000_BBBB; refm[32'h44] = 32'h0000_BBBB;
    do_reset();

    // Read miss fills set 8 in S via two BusRd words.
    blog.delete();
    access(32'h40, 1'b0, '0);
    chk("rdmiss_words", blog.size(), 32'd2);
    chk_log(0, 32'h40, 1'b0, 1'b0);
    chk_log(1, 32'h44, 1'b0, 1'b0);
    chk("rdmiss_load", dmemload, 32'h0000_AAAA);

    // Write to S line refills with BusRdX, then the store lands in word1.
    blog.delete();
    access(32'h44, 1'b1, 32'h1234);
    chk_log(0, 32'h40, 1'b0, 1'b1);
    chk_log(1, 32'h44, 1'b0, 1'b1);
    access(32'h44, 1'b0, '0);
    chk("wr_word1", dmemload, 32'h1234);

    // Invalidating snoop of the M line writes both words back.
    snoop(32'h40, 1'b1);
    chk_log(0, 32'h40, 1'b1, 1'b0);
    chk_log(1, 32'h44, 1'b1, 1'b0);
    chk("snoop_mem1", mem_rd(32'h44), 32'h1234);
    access(32'h40, 1'b0, '0);

    // Dirty victim with a different tag is written back before the refill.
    access(32'h40, 1'b1, 32'h7777);
    blog.delete();
    access(32'h440, 1'b0, '0);
    chk("victim_words", blog.size(), 32'd4);
    chk_log(0, 32'h40, 1'b1, 1'b0);
    chk_log(1, 32'h44, 1'b1, 1'b0);
    chk_log(2, 32'h440, 1'b0, 1'b0);
    chk_log(3, 32'h444, 1'b0, 1'b0);
    chk("victim_mem0", mem_rd(32'h40), 32'h7777);

    // Random mix of accesses and snoops over a small aliasing address pool.
    rand_lat = 1'b1;
    for (int k = 0; k < 150; k++) begin
      a = {23'd0, 2'($urandom_range(0, 2)), 2'b00, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'b00};
      if ($urandom_range(0, 3) == 0) snoop(a, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 1) == 0) access(a, 1'b1, $urandom);
      else access(a, 1'b0, '0);
      if ($urandom_range(0, 1) == 0) tick();
    end
    do_flush();
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 2; b++) begin
          a = (t << 7) | (i << 3) | (b << 2);
          chk("flush_coherent", mem_rd(a), ref_rd(a));
        end
    snoop(32'h48, 1'b1);
    chk("flushed_hold", {31'd0, flushed}, 32'd1);

    // Flush with exactly sets 2 and 5 dirty.
    rand_lat = 1'b0;
    do_reset();
    access(32'h10, 1'b1, 32'hCAFE_0010);
    access(32'h2C, 1'b1, 32'hCAFE_002C);
    blog.delete();
    do_flush();
    chk("flush_words", blog.size(), 32'd4);
    chk_log(0, 32'h10, 1'b1, 1'b0);
    chk_log(1, 32'h14, 1'b1, 1'b0);
    chk_log(2, 32'h28, 1'b1, 1'b0);
    chk_log(3, 32'h2C, 1'b1, 1'b0);
    chk("flush_data0", mem_rd(32'h10), 32'hCAFE_0010);
    chk("flush_data1", mem_rd(32'h2C), 32'hCAFE_002C);
    tick(); tick();
    chk("flushed_stays", {31'd0, flushed}, 32'd1);

    // Reset during the second refill word abandons the fill.
    do_reset();
    dmemaddr = 32'h88; dmemREN = 1'b1;
    n = 0;
    while (!(dREN && daddr == 32'h8C) && n < 40) begin tick(); n++; end
    chk("alloc1_reached", {31'd0, dREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk_reset_outputs("midfill_reset");
    tick();
    nRST = 1'b1; dmemREN = 1'b0;
    model_clear();
    tick();
    access(32'h88, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coherent_dcache.md
COHERENT_DCACHE -- requirements
Module: coherent_dcache

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low; ports CLK and nRST.
REQ-002 SHALL have ports: CLK in 1 clock; nRST in 1 async active-low reset.
REQ-003 SHALL have datapath ports: dmemREN in 1; dmemWEN in 1; dmemaddr in 32; dmemstore in 32; halt in 1; dhit out 1; dmemload out 32; flushed out 1.
REQ-004 SHALL have bus request ports: dREN out 1; dWEN out 1; ccwrite out 1 (1 = BusRdX, 0 = BusRd); daddr out 32; dstore out 32; dload in 32; dwait in 1 (0 = current word done).
REQ-005 SHALL have snoop ports: ccwait in 1 (snoop pending); ccinv in 1 (invalidate on snoop); ccsnoopaddr in 32; cctrans out 1 (snoop acknowledged).

Function
REQ-006 SHALL be direct-mapped, 16 sets, 2-word blocks; address split tag[31:7], index[6:3], blkoff[2], byteoff[1:0]=00.
REQ-007 SHALL keep per-set MSI state (I/S/M), tag, and two data words.
REQ-008 SHALL implement FSM states IDLE, SNOOP, SNOOP_WB0, SNOOP_WB1, WB0, WB1, ALLOC0, ALLOC1, FLUSH_WB0, FLUSH_WB1, FLUSHED.
REQ-009 SHALL give ccwait priority: in any state where bus outputs are idle (IDLE or ALLOC0 entry before dREN asserts), ccwait=1 moves to SNOOP; an in-progress own transfer is never interrupted.
REQ-010 SHALL, in SNOOP, assert cctrans=1 for exactly one cycle; dWEN=1 in that cycle iff snooped set is M with matching tag; daddr = snooped block word 0.
REQ-011 SHALL, on M-hit snoop, go SNOOP_WB0 -> SNOOP_WB1 driving dWEN=1, dstore=word0/word1, daddr=block+0/+4, advancing on dwait=0; then the set becomes I if ccinv latched =1, else S.
REQ-012 SHALL, on S-hit snoop, set I if ccinv=1, else keep S; on miss, change nothing; return to IDLE after SNOOP.
REQ-013 SHALL assert dhit=1 combinationally in IDLE when tag matches and: read with state S/M, or write with state M.
REQ-014 SHALL, on write hit in M, update the addressed word at the clock edge; read hit returns word on dmemload the same cycle.
REQ-015 SHALL, on miss (or write to S), go WB0 if victim is M with different tag, else ALLOC0.
REQ-016 SHALL in WB0/WB1 drive dWEN=1, ccwrite=0, victim address/data; advance on dwait=0; then ALLOC0.
REQ-017 SHALL in ALLOC0/ALLOC1 drive dREN=1, ccwrite=dmemWEN, daddr=block+0/+4; latch dload into word0/word1 on dwait=0.
REQ-018 SHALL, after ALLOC1 completes, set tag and state M if dmemWEN else S, and return to IDLE (request then hits).
REQ-019 SHALL, on halt in IDLE, walk sets 0..15 with a 4-bit counter, writing back each M set via FLUSH_WB0/1 (dWEN=1) and marking every set I; skip non-M sets at one per cycle.
REQ-020 SHALL service snoops during flush between sets (REQ-009).
REQ-021 SHALL enter FLUSHED after set 15, hold flushed=1 and remain there until reset; still answer snoops with cctrans (no data).
REQ-022 SHALL never assert dREN and dWEN together; cctrans only in SNOOP.

Reset
REQ-023 SHALL on nRST=0 asynchronously clear all MSI states to I, tags and data to 0, FSM to IDLE, flush counter to 0.
REQ-024 SHALL drive all outputs 0 during reset; reset mid-transfer abandons it with no write committed.

Structure
REQ-025 SHALL take the MSI enum, FSM state enum and address-field struct from cpu_types_pkg.
REQ-026 SHALL be one module; no sub-module is required.

Verification
REQ-027 Read miss 0x0000_0040, dload=0xAAAA/0xBBBB with dwait=0 per word -> dREN, ccwrite=0, daddr 0x40 then 0x44; set 8 S; dmemload=0xAAAA, dhit=1.
REQ-028 Write 0x1234 to 0x44 on S line -> BusRdX (ccwrite=1) refill, set M, word1=0x1234 after dhit.
REQ-029 Set 8 M, ccwait=1, ccinv=1, ccsnoopaddr=0x40 -> cctrans=1 and dWEN=1 same cycle, dstore word0 then word1, set 8 I.
REQ-030 Set 8 M tag A, read miss 0x440 -> WB0/WB1 to 0x40/0x44, then ALLOC 0x440/0x444.
REQ-031 Sets 2 and 5 M, halt=1 -> exactly 4 dWEN words at their addresses, flushed=1 after set 15.
REQ-032 nRST=0 during ALLOC1 -> all outputs 0, next read to same address misses.
